// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : I2C target. Samples SCL/SDA with the system clock, detects
//            START/STOP, matches a 7-bit address, pushes received bytes into
//            an RX FIFO and shifts TX FIFO bytes out on reads. Open-drain SDA
//            drive (0 = pull low, 1 = release); no clock stretching.
// Ports    : clk, rst (async, active-low)
//            scl_i, sda_i      - asynchronous bus lines
//            sda_o             - SDA drive
//            tx_data/tx_valid  - TX FIFO head / not empty; tx_rd pops
//            rx_data/rx_wr     - received byte / one-clk push; rx_full input
//            busy, rw          - transfer in progress / R/W of matched address
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_rd,
    output logic [7:0] rx_data,
    output logic       rx_wr,
    input  logic       rx_full,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX_DATA  = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX_DATA  = 3'd5,
        S_TX_ACK   = 3'd6
    } state_t;

    // Synchronisers plus a history stage for edge detection. They reset to
    // the idle-bus level so leaving reset never fakes an edge.
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = ~r_sda_s2 & r_sda_d & r_scl_s2;
    assign w_stop     = r_sda_s2 & ~r_sda_d & r_scl_s2;

    state_t     r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [7:0] r_shreg, w_shreg;
    logic [7:0] r_txsh, w_txsh;
    logic       r_done, w_done;       // 8th bit of the byte has been sampled
    logic       r_ack, w_ack;         // master ACK sampled during TX_ACK
    logic       r_sda, w_sda;
    logic       r_rw, w_rw;
    logic       r_busy, w_busy;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_wr, w_rx_wr;
    logic       r_tx_rd, w_tx_rd;

    logic [2:0] w_cnt_m1;
    logic [7:0] w_tx_byte;
    assign w_cnt_m1  = r_bit_cnt - 3'd1;
    assign w_tx_byte = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd7;
            r_shreg   <= 8'h00;
            r_txsh    <= 8'h00;
            r_done    <= 1'b0;
            r_ack     <= 1'b1;
            r_sda     <= 1'b1;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_rx_data <= 8'h00;
            r_rx_wr   <= 1'b0;
            r_tx_rd   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shreg   <= w_shreg;
            r_txsh    <= w_txsh;
            r_done    <= w_done;
            r_ack     <= w_ack;
            r_sda     <= w_sda;
            r_rw      <= w_rw;
            r_busy    <= w_busy;
            r_rx_data <= w_rx_data;
            r_rx_wr   <= w_rx_wr;
            r_tx_rd   <= w_tx_rd;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shreg   = r_shreg;
        w_txsh    = r_txsh;
        w_done    = r_done;
        w_ack     = r_ack;
        w_sda     = r_sda;
        w_rw      = r_rw;
        w_busy    = r_busy;
        w_rx_data = r_rx_data;
        w_rx_wr   = 1'b0;
        w_tx_rd   = 1'b0;

        // Bus conditions take priority over bit processing in every state.
        if (w_start) begin
            w_state   = S_ADDR;
            w_bit_cnt = 3'd7;
            w_done    = 1'b0;
            w_sda     = 1'b1;
        end else if (w_stop) begin
            w_state = S_IDLE;
            w_sda   = 1'b1;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda = 1'b1;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shreg = {r_shreg[6:0], r_sda_s2};
                        if (r_bit_cnt == 3'd0) w_done = 1'b1;
                        else                   w_bit_cnt = w_cnt_m1;
                    end else if (w_scl_fall && r_done) begin
                        w_done = 1'b0;
                        if (r_shreg[7:1] == SLV_ADDR) begin
                            w_rw    = r_shreg[0];
                            w_busy  = 1'b1;
                            w_sda   = 1'b0;
                            w_state = S_ADDR_ACK;
                        end else begin
                            w_busy  = 1'b0;
                            w_state = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK, S_TX_ACK: begin
                    if (r_state == S_TX_ACK && w_scl_rise) begin
                        w_ack = r_sda_s2;
                    end else if (w_scl_fall) begin
                        if (r_state == S_ADDR_ACK && !r_rw) begin
                            w_sda     = 1'b1;
                            w_bit_cnt = 3'd7;
                            w_done    = 1'b0;
                            w_state   = S_RX_DATA;
                        end else if (r_state == S_TX_ACK && r_ack) begin
                            w_sda   = 1'b1;
                            w_busy  = 1'b0;
                            w_state = S_IDLE;
                        end else begin
                            // Empty FIFO still needs a byte on the wire: 0xFF
                            // leaves SDA released and pops nothing.
                            w_txsh    = w_tx_byte;
                            w_tx_rd   = tx_valid;
                            w_sda     = w_tx_byte[7];
                            w_bit_cnt = 3'd7;
                            w_state   = S_TX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (w_scl_rise) begin
                        w_shreg = {r_shreg[6:0], r_sda_s2};
                        if (r_bit_cnt == 3'd0) w_done = 1'b1;
                        else                   w_bit_cnt = w_cnt_m1;
                    end else if (w_scl_fall && r_done) begin
                        w_done = 1'b0;
                        if (!rx_full) begin
                            w_rx_data = r_shreg;
                            w_rx_wr   = 1'b1;
                            w_sda     = 1'b0;
                        end else begin
                            w_sda = 1'b1;
                        end
                        w_state = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda     = 1'b1;
                        w_bit_cnt = 3'd7;
                        w_done    = 1'b0;
                        w_state   = S_RX_DATA;
                    end
                end
                S_TX_DATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            w_sda   = 1'b1;
                            w_ack   = 1'b1;
                            w_state = S_TX_ACK;
                        end else begin
                            w_bit_cnt = w_cnt_m1;
                            w_sda     = r_txsh[w_cnt_m1];
                        end
                    end
                end
                default: begin
                    w_sda   = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign sda_o   = r_sda;
    assign tx_rd   = r_tx_rd;
    assign rx_data = r_rx_data;
    assign rx_wr   = r_rx_wr;
    assign busy    = r_busy;
    assign rw      = r_rw;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Purpose  : Self-checking bench for i2c_slave. A bus-master model drives
//            SCL/SDA (wired-AND with the target's sda_o); RX pushes and TX
//            pops are checked by monitors against expected-value queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int c_q = 100;   // quarter SCL period in ns (10 clk)

    logic       clk;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_o;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_rd;
    logic [7:0] rx_data;
    logic       rx_wr;
    logic       rx_full;
    logic       busy;
    logic       rw;

    assign sda_bus = m_sda & sda_o;

    i2c_slave #(.SLV_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (m_scl),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_rd    (tx_rd),
        .rx_data  (rx_data),
        .rx_wr    (rx_wr),
        .rx_full  (rx_full),
        .busy     (busy),
        .rw       (rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    logic sda_low_seen = 1'b0;

    logic [7:0] tx_fifo[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        tx_valid = (tx_fifo.size() > 0);
        tx_data  = (tx_fifo.size() > 0) ? tx_fifo[0] : 8'h00;
    endtask

    // Monitor: checks every FIFO strobe against the scoreboard queues and
    // models the TX FIFO pop.
    always @(negedge clk) begin
        if (!sda_o) sda_low_seen = 1'b1;
        if (rx_wr || tx_rd) chk1("rx_wr_tx_rd_exclusive", rx_wr & tx_rd, 1'b0);
        if (rx_wr) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_wr_unexpected: got rx_data %02h expected no push at %0t", rx_data, $time);
            end else begin
                chk8("rx_data", rx_data, exp_rx.pop_front());
            end
        end
        if (tx_rd) begin
            tx_cnt++;
            if (exp_tx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_rd_unexpected: got tx_rd with head %02h expected no pop at %0t", tx_data, $time);
            end else begin
                chk8("tx_pop_data", tx_data, exp_tx.pop_front());
            end
            if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
            refresh_fifo();
        end
    end

    // ---------------- bus master model ----------------
    task automatic bit_xfer(input logic b, output logic s);
        m_sda = b;    #(c_q);
        m_scl = 1'b1; #(c_q);
        s = sda_bus;  #(c_q);
        m_scl = 1'b0; #(c_q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    task automatic start_c();
        m_sda = 1'b1; #(c_q);
        m_scl = 1'b1; #(c_q);
        m_sda = 1'b0; #(c_q);
        m_scl = 1'b0; #(c_q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; #(c_q);
        m_scl = 1'b1; #(c_q);
        m_sda = 1'b1; #(c_q);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         rx_snap;
        int         tx_snap;

        rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rx_full = 1'b0;
        refresh_fifo();
        repeat (4) @(negedge clk);
        chk1("reset_sda_o", sda_o, 1'b1);
        chk1("reset_tx_rd", tx_rd, 1'b0);
        chk1("reset_rx_wr", rx_wr, 1'b0);
        chk8("reset_rx_data", rx_data, 8'h00);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_rw", rw, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Write: A0, 3C, 5A
        start_c();
        write_byte(8'hA0, ack); chk1("wr_addr_ack", ack, 1'b0);
        chk1("wr_busy", busy, 1'b1);
        chk1("wr_rw", rw, 1'b0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack); chk1("wr_d0_ack", ack, 1'b0);
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ack); chk1("wr_d1_ack", ack, 1'b0);
        stop_c();
        chk1("wr_busy_after_stop", busy, 1'b0);
        chki("wr_rx_count", rx_cnt, 2);

        // Address mismatch: A2, 11
        sda_low_seen = 1'b0;
        rx_snap = rx_cnt; tx_snap = tx_cnt;
        start_c();
        write_byte(8'hA2, ack); chk1("mm_addr_nack", ack, 1'b1);
        write_byte(8'h11, ack); chk1("mm_data_nack", ack, 1'b1);
        stop_c();
        chk1("mm_sda_never_low", sda_low_seen, 1'b0);
        chk1("mm_busy", busy, 1'b0);
        chki("mm_no_rx_wr", rx_cnt, rx_snap);
        chki("mm_no_tx_rd", tx_cnt, tx_snap);

        // Read: FIFO C3, 7E; ACK first byte, NACK second
        tx_fifo.push_back(8'hC3); tx_fifo.push_back(8'h7E); refresh_fifo();
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'h7E);
        start_c();
        write_byte(8'hA1, ack); chk1("rd_addr_ack", ack, 1'b0);
        chk1("rd_rw", rw, 1'b1);
        read_byte(1'b0, d); chk8("rd_byte0", d, 8'hC3);
        read_byte(1'b1, d); chk8("rd_byte1", d, 8'h7E);
        chk1("rd_idle_after_nack_busy", busy, 1'b0);
        chk1("rd_sda_released", sda_o, 1'b1);
        stop_c();
        chki("rd_tx_count", tx_cnt, 2);

        // RX FIFO full on the second data byte
        start_c();
        write_byte(8'hA0, ack); chk1("full_addr_ack", ack, 1'b0);
        exp_rx.push_back(8'h01);
        write_byte(8'h01, ack); chk1("full_d0_ack", ack, 1'b0);
        rx_full = 1'b1;
        write_byte(8'h02, ack); chk1("full_d1_nack", ack, 1'b1);
        rx_full = 1'b0;
        stop_c();
        chki("full_rx_count", rx_cnt, 3);

        // Repeated start into a read with an empty TX FIFO
        tx_snap = tx_cnt;
        start_c();
        write_byte(8'hA0, ack); chk1("rs_addr_w_ack", ack, 1'b0);
        exp_rx.push_back(8'h10);
        write_byte(8'h10, ack); chk1("rs_d0_ack", ack, 1'b0);
        start_c();
        write_byte(8'hA1, ack); chk1("rs_addr_r_ack", ack, 1'b0);
        chk1("rs_rw", rw, 1'b1);
        read_byte(1'b1, d); chk8("rs_empty_byte", d, 8'hFF);
        stop_c();
        chki("rs_no_tx_rd", tx_cnt, tx_snap);
        chki("rs_rx_count", rx_cnt, 4);

        // Asynchronous reset during bit 3 of a read of 0x00
        tx_fifo.push_back(8'h00); refresh_fifo();
        exp_tx.push_back(8'h00);
        start_c();
        write_byte(8'hA1, ack); chk1("rst_addr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
        m_sda = 1'b1; #(c_q);
        m_scl = 1'b1; #(c_q / 2);
        chk1("rst_sda_low_before", sda_o, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("rst_async_sda_o", sda_o, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rw", rw, 1'b0);
        chk8("rst_rx_data", rx_data, 8'h00);
        chk1("rst_rx_wr", rx_wr, 1'b0);
        chk1("rst_tx_rd", tx_rd, 1'b0);
        #(c_q / 2 - 3);
        m_scl = 1'b0; #(c_q);
        rst = 1'b1;   #(c_q);
        stop_c();
        start_c();
        write_byte(8'hA0, ack); chk1("post_rst_addr_ack", ack, 1'b0);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack); chk1("post_rst_d0_ack", ack, 1'b0);
        stop_c();
        chk1("post_rst_busy", busy, 1'b0);

        #(c_q);
        chki("final_rx_count", rx_cnt, 5);
        chki("final_tx_count", tx_cnt, 3);
        chki("exp_rx_drained", exp_rx.size(), 0);
        chki("exp_tx_drained", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
